pong_tick_scheduler: RTL and testbench

Sequences the game-tick timer for FPGA Pong and distributes its terminal-count pulses to the game clients. It drives the timer's enable, counts its `Tc` pulses, and issues single-cycle step strobes to the ball and paddle logic. It also runs the serve countdown after every point and handles pause/resume. It sits between the tick timer and the ball/paddle position registers.

---
 rtl/pong_pkg.sv | 17 +
 rtl/step_divider.sv | 38 +++
 rtl/pong_tick_scheduler.sv | 157 +++++++++++++++
 tb/tb_pong_tick_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong tick scheduler: state encodings, counter width
// and default timing constants.
package pong_pkg;

    localparam int unsigned CNT_W           = 8;
    localparam int unsigned DEF_BALL_DIV    = 2;
    localparam int unsigned DEF_PADDLE_DIV  = 1;
    localparam int unsigned DEF_SERVE_TICKS = 60;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

endpackage

// File: rtl/step_divider.sv
// Modulo-N prescaler: counts Tick pulses and emits a registered one-cycle Strobe on
// every N-th one, where N is the divisor presented on Div (1..255).
module step_divider
    import pong_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clear,
    input  logic             Tick,
    input  logic [CNT_W-1:0] Div,
    output logic             Strobe
);

    logic [CNT_W-1:0] cnt_q;
    logic             strobe_q;
    logic             wrap;

    // >= rather than == so a shrinking divisor can never strand the count above it
    assign wrap = (cnt_q >= (Div - CNT_W'(1)));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else if (Clear) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else if (Tick) begin
            cnt_q    <= wrap ? '0 : cnt_q + CNT_W'(1);
            strobe_q <= wrap;
        end else begin
            strobe_q <= 1'b0;
        end
    end

    assign Strobe = strobe_q;

endmodule

// File: rtl/pong_tick_scheduler.sv
// Game-tick sequencer for Pong: serve countdown, play, pause/resume and step strobes.
// Define PONG_SPEEDUP_EN to shrink the ball divisor after every fourth paddle hit.
module pong_tick_scheduler
    import pong_pkg::*;
#(
    parameter int unsigned BALL_DIV    = DEF_BALL_DIV,
    parameter int unsigned PADDLE_DIV  = DEF_PADDLE_DIV,
    parameter int unsigned SERVE_TICKS = DEF_SERVE_TICKS
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tc,
    input  logic       Start,
    input  logic       PauseReq,
    input  logic       PointScored,
    input  logic       Hit,
    output logic       TimerEn,
    output logic       BallStep,
    output logic       PaddleStep,
    output logic       Serving,
    output logic [1:0] State
);

    if (SERVE_TICKS < 1 || SERVE_TICKS > 255 || BALL_DIV < 1 || BALL_DIV > 255 ||
        PADDLE_DIV < 1 || PADDLE_DIV > 255) begin : g_bad_param
        $error("pong_tick_scheduler: parameter out of range 1..255");
    end

    state_e           state_q, state_d;
    state_e           resume_q, resume_d;
    logic [CNT_W-1:0] serve_q, serve_d;
    logic             timer_en_q, serving_q;
    logic             ball_tick, paddle_tick, ball_clr, paddle_clr, point_restart;
    logic             ball_div_clr;
    logic [CNT_W-1:0] ball_div;

    always_comb begin
        state_d       = state_q;
        resume_d      = resume_q;
        serve_d       = serve_q;
        ball_tick     = 1'b0;
        paddle_tick   = 1'b0;
        ball_clr      = 1'b0;
        paddle_clr    = 1'b0;
        point_restart = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_SERVE;
                    serve_d = CNT_W'(SERVE_TICKS);
                end
            end
            ST_SERVE: begin
                if (PauseReq) begin
                    state_d  = ST_PAUSE;
                    resume_d = ST_SERVE;
                end else if (Tc) begin
                    serve_d = serve_q - CNT_W'(1);
                    // Final countdown tick is consumed by the transition, so no strobe
                    if (serve_q == CNT_W'(1)) begin
                        state_d    = ST_PLAY;
                        ball_clr   = 1'b1;
                        paddle_clr = 1'b1;
                    end else begin
                        paddle_tick = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (PointScored) begin
                    state_d       = ST_SERVE;
                    serve_d       = CNT_W'(SERVE_TICKS);
                    ball_clr      = 1'b1;
                    point_restart = 1'b1;
                end else if (PauseReq) begin
                    state_d  = ST_PAUSE;
                    resume_d = ST_PLAY;
                end else if (Tc) begin
                    ball_tick   = 1'b1;
                    paddle_tick = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (!PauseReq) state_d = resume_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            resume_q   <= ST_SERVE;
            serve_q    <= '0;
            timer_en_q <= 1'b0;
            serving_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            serve_q    <= serve_d;
            timer_en_q <= (state_d == ST_SERVE) || (state_d == ST_PLAY);
            serving_q  <= (state_d == ST_SERVE);
        end
    end

`ifdef PONG_SPEEDUP_EN
    logic [1:0]       hit_q;
    logic [CNT_W-1:0] ball_div_q;
    logic             hit_play;

    assign hit_play     = (state_q == ST_PLAY) && !PointScored && Hit;
    assign ball_div_clr = hit_play && (hit_q == 2'd3) && (ball_div_q > CNT_W'(1));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            hit_q      <= '0;
            ball_div_q <= CNT_W'(BALL_DIV);
        end else if (point_restart) begin
            hit_q      <= '0;
            ball_div_q <= CNT_W'(BALL_DIV);
        end else if (hit_play) begin
            hit_q <= hit_q + 2'd1;
            if (ball_div_clr) ball_div_q <= ball_div_q - CNT_W'(1);
        end
    end

    assign ball_div = ball_div_q;
`else
    logic unused_hit;
    assign unused_hit   = Hit;
    assign ball_div_clr = 1'b0;
    assign ball_div     = CNT_W'(BALL_DIV);
`endif

    step_divider u_ball_div (
        .Clk    (Clk),
        .Rst    (Rst),
        .Clear  (ball_clr | ball_div_clr),
        .Tick   (ball_tick),
        .Div    (ball_div),
        .Strobe (BallStep)
    );

    step_divider u_paddle_div (
        .Clk    (Clk),
        .Rst    (Rst),
        .Clear  (paddle_clr),
        .Tick   (paddle_tick),
        .Div    (CNT_W'(PADDLE_DIV)),
        .Strobe (PaddleStep)
    );

    assign TimerEn = timer_en_q;
    assign Serving = serving_q;
    assign State   = state_q;

endmodule

// File: tb/tb_pong_tick_scheduler.sv
// Self-checking bench for pong_tick_scheduler: directed game scenarios then random play,
// every cycle compared against a tick-counting reference model.
module tb_pong_tick_scheduler;

    localparam int unsigned BD = 2;
    localparam int unsigned PD = 1;
    localparam int unsigned ST = 3;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Tc = 1'b0, Start = 1'b0, PauseReq = 1'b0, PointScored = 1'b0, Hit = 1'b0;
    logic       TimerEn, BallStep, PaddleStep, Serving;
    logic [1:0] State;

    int compared   = 0;
    int mismatched = 0;
    int n_ball     = 0;
    int n_pad      = 0;

    // Reference model: modes 0 idle, 1 serve, 2 play, 3 pause; tick counts since last clear
    int m_state  = 0;
    int m_resume = 1;
    int m_serve  = 0;
    int m_bacc   = 0;
    int m_pacc   = 0;
    int m_bdiv   = BD;
    int m_hits   = 0;
    bit e_ball   = 1'b0;
    bit e_pad    = 1'b0;

    pong_tick_scheduler #(
        .BALL_DIV    (BD),
        .PADDLE_DIV  (PD),
        .SERVE_TICKS (ST)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Tc          (Tc),
        .Start       (Start),
        .PauseReq    (PauseReq),
        .PointScored (PointScored),
        .Hit         (Hit),
        .TimerEn     (TimerEn),
        .BallStep    (BallStep),
        .PaddleStep  (PaddleStep),
        .Serving     (Serving),
        .State       (State)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit tc, input bit start, input bit pause, input bit pt,
                         input bit hit, input bit rst_n);
        int old;
        old    = m_state;
        e_ball = 1'b0;
        e_pad  = 1'b0;
        if (!rst_n) begin
            m_state  = 0;
            m_resume = 1;
            m_serve  = 0;
            m_bacc   = 0;
            m_pacc   = 0;
            m_bdiv   = BD;
            m_hits   = 0;
            return;
        end
        case (old)
            0: if (start) begin
                m_state = 1;
                m_serve = ST;
            end
            1: if (pause) begin
                m_resume = 1;
                m_state  = 3;
            end else if (tc) begin
                m_serve--;
                if (m_serve == 0) begin
                    m_state = 2;
                    m_bacc  = 0;
                    m_pacc  = 0;
                end else begin
                    m_pacc++;
                    e_pad = (m_pacc % PD) == 0;
                end
            end
            2: if (pt) begin
                m_state = 1;
                m_serve = ST;
                m_bacc  = 0;
            end else if (pause) begin
                m_resume = 2;
                m_state  = 3;
            end else if (tc) begin
                m_bacc++;
                m_pacc++;
                e_ball = (m_bacc % m_bdiv) == 0;
                e_pad  = (m_pacc % PD) == 0;
            end
            default: if (!pause) m_state = m_resume;
        endcase
`ifdef PONG_SPEEDUP_EN
        if (old == 2 && pt) begin
            m_bdiv = BD;
            m_hits = 0;
        end else if (old == 2 && hit) begin
            m_hits = (m_hits + 1) % 4;
            if (m_hits == 0 && m_bdiv > 1) begin
                m_bdiv--;
                m_bacc = 0;
                e_ball = 1'b0;
            end
        end
`else
        if (old == 2 && hit) m_hits++;
`endif
    endtask

    task automatic step(input bit tc, input bit start, input bit pause, input bit pt,
                        input bit hit, input bit rst_n);
        @(negedge Clk);
        Tc = tc; Start = start; PauseReq = pause; PointScored = pt; Hit = hit; Rst = rst_n;
        @(posedge Clk);
        model(tc, start, pause, pt, hit, rst_n);
        #1;
        check("state", 16'(State), 16'(m_state));
        check("timer_en", 16'(TimerEn), 16'(m_state == 1 || m_state == 2));
        check("serving", 16'(Serving), 16'(m_state == 1));
        check("ball_step", 16'(BallStep), 16'(e_ball));
        check("paddle_step", 16'(PaddleStep), 16'(e_pad));
        n_ball += int'(BallStep);
        n_pad  += int'(PaddleStep);
    endtask

    // One Tc every 5 cycles
    task automatic period(input bit pause, input bit pt);
        step(1'b1, 1'b0, pause, pt, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, pause, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bit pause_lvl;

        // 1: reset, start, serve countdown
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("s1_serve_state", 16'(State), 16'd1);
        n_ball = 0; n_pad = 0;
        repeat (3) period(1'b0, 1'b0);
        check("s1_play_state", 16'(State), 16'd2);
        check("s1_paddles", 16'(n_pad), 16'd2);
        check("s1_balls", 16'(n_ball), 16'd0);

        // 2: four play ticks
        n_ball = 0; n_pad = 0;
        repeat (4) period(1'b0, 1'b0);
        check("s2_paddles", 16'(n_pad), 16'd4);
        check("s2_balls", 16'(n_ball), 16'd2);

        // 3: pause holds prescalers
        period(1'b0, 1'b0);
        n_ball = 0; n_pad = 0;
        repeat (3) period(1'b1, 1'b0);
        check("s3_paused_strobes", 16'(n_ball + n_pad), 16'd0);
        check("s3_paused_timer", 16'(TimerEn), 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("s3_resume_state", 16'(State), 16'd2);
        period(1'b0, 1'b0);
        check("s3_ball_after", 16'(n_ball), 16'd1);

        // 4: point with coincident Tc, then pause during serve
        n_ball = 0; n_pad = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("s4_no_strobe", 16'(n_ball + n_pad), 16'd0);
        check("s4_serve_state", 16'(State), 16'd1);
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("s4_resume_serve", 16'(State), 16'd1);
        repeat (3) period(1'b0, 1'b0);
        check("s4_serve_len", 16'(State), 16'd2);

        // 5: mid-play reset, ticks ignored until Start
        repeat (2) period(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s5_reset_state", 16'(State), 16'd0);
        n_ball = 0; n_pad = 0;
        repeat (3) period(1'b0, 1'b0);
        check("s5_idle_strobes", 16'(n_ball + n_pad), 16'd0);

`ifdef PONG_SPEEDUP_EN
        // 6: speed-up
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) period(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_ball = 0;
        repeat (4) period(1'b0, 1'b0);
        check("s6_div1", 16'(n_ball), 16'd4);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_ball = 0;
        repeat (2) period(1'b0, 1'b0);
        check("s6_div_sat", 16'(n_ball), 16'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) period(1'b0, 1'b0);
        n_ball = 0;
        repeat (4) period(1'b0, 1'b0);
        check("s6_div_restored", 16'(n_ball), 16'd2);
`endif

        // Random play, including back-to-back Tc and occasional resets
        pause_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) pause_lvl = ~pause_lvl;
            step(($urandom_range(2) == 0) || (i % 200 < 20),
                 $urandom_range(7) == 0,
                 pause_lvl,
                 $urandom_range(15) == 0,
                 $urandom_range(3) == 0,
                 $urandom_range(499) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
